// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared definitions for the data-memory arbiter: arbitration
//               state encoding, response owner id, memory map limit and the
//               default fairness / burst limits.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Arbitration mode. S_NORM uses CPU-first priority with a starvation
  // escape for the DMA port. S_BURST keeps the DMA port granted while it
  // holds its lock, up to the burst cap.
  typedef enum logic [0:0] {
    S_NORM  = 1'b0,
    S_BURST = 1'b1
  } arb_state_e;

  // Which requester a registered response belongs to.
  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Highest byte address backed by the 12 KB data memory.
  localparam logic [31:0] c_DM_TOP = 32'h0000_2FFF;

  // Default consecutive denied DMA cycles before DMA is forced a slot.
  localparam int unsigned c_STARVE_MAX_DEF = 8;

  // Default maximum consecutive locked DMA grants.
  localparam int unsigned c_MAX_BURST_DEF = 16;

  // True when a byte address falls inside the mapped data memory.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] top);
    return (addr <= top);
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/arb_resp.sv
`default_nettype none
// ============================================================================
// Module      : arb_resp
// Description : Registered response stage of the data-memory arbiter. Records
//               who was granted in cycle N and whether the access was an
//               in-range read or an out-of-range access, then issues the
//               matching rvalid / err pulse in cycle N+1. Read data comes
//               straight from the memory in the response cycle and is also
//               captured so rdata holds the last returned word afterwards.
// Revision    : 1.0 - initial release
//
// Ports
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   i_valid       in   1   an access was granted this cycle
//   i_owner_dma   in   1   granted requester is DMA (1) or CPU (0)
//   i_read        in   1   granted access is a read
//   i_err         in   1   granted access is outside the mapped range
//   i_mem_dout    in  32   memory read data (valid the cycle after address)
//   o_cpu_rvalid  out  1   CPU read data valid pulse
//   o_cpu_err     out  1   CPU out-of-range pulse
//   o_dma_rvalid  out  1   DMA read data valid pulse
//   o_dma_err     out  1   DMA out-of-range pulse
//   o_rdata       out 32   shared read data
// ============================================================================
module arb_resp
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_owner_dma,
  input  logic        i_read,
  input  logic        i_err,
  input  logic [31:0] i_mem_dout,
  output logic        o_cpu_rvalid,
  output logic        o_cpu_err,
  output logic        o_dma_rvalid,
  output logic        o_dma_err,
  output logic [31:0] o_rdata
);

  owner_e      r_owner;
  logic        r_rvalid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_rvalid;
  logic        w_err;

  // A pulse registered before a reset edge must not reach the requesters
  // while reset is asserted, so the flags are masked by rst as well.
  assign w_rvalid = r_rvalid & ~rst;
  assign w_err    = r_err & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= OWN_CPU;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_owner  <= i_owner_dma ? OWN_DMA : OWN_CPU;
      r_rvalid <= i_valid & i_read & ~i_err;
      r_err    <= i_valid & i_err;
      if (w_rvalid) begin
        r_rdata <= i_mem_dout;
      end
    end
  end

  assign o_cpu_rvalid = w_rvalid & (r_owner == OWN_CPU);
  assign o_dma_rvalid = w_rvalid & (r_owner == OWN_DMA);
  assign o_cpu_err    = w_err & (r_owner == OWN_CPU);
  assign o_dma_err    = w_err & (r_owner == OWN_DMA);

  // The memory presents its word in the response cycle; outside that cycle
  // the last returned word is held.
  assign o_rdata = w_rvalid ? i_mem_dout : r_rdata;

endmodule : arb_resp
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Two-port arbiter sharing the 12 KB data memory between the
//               CPU datapath and a DMA/loader requester. Grant is decided
//               combinationally each cycle from the registered arbitration
//               state and the live requests; the winner drives the memory in
//               the same cycle and its response (rvalid or err) follows one
//               cycle later. The CPU sees a stall whenever it requests and
//               loses.
// Revision    : 1.0 - initial release
//
// Ports
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   i_cpu_req     in   1   CPU access request
//   i_cpu_we      in   1   CPU write (1) / read (0)
//   i_cpu_addr    in  32   CPU byte address
//   i_cpu_wdata   in  32   CPU write data
//   i_cpu_be      in   4   CPU byte enables
//   o_cpu_stall   out  1   CPU requesting but not granted this cycle
//   o_cpu_rvalid  out  1   CPU read data valid pulse
//   o_cpu_err     out  1   CPU out-of-range pulse
//   i_dma_req     in   1   DMA access request
//   i_dma_we      in   1   DMA write (1) / read (0)
//   i_dma_addr    in  32   DMA byte address
//   i_dma_wdata   in  32   DMA write data
//   i_dma_be      in   4   DMA byte enables
//   i_dma_lock    in   1   DMA asks to keep the grant for a burst
//   o_dma_gnt     out  1   DMA granted this cycle
//   o_dma_rvalid  out  1   DMA read data valid pulse
//   o_dma_err     out  1   DMA out-of-range pulse
//   o_rdata       out 32   shared read data, qualified by *_rvalid
//   o_mem_addr    out 12   word address to memory
//   o_mem_din     out 32   write data to memory
//   o_mem_be      out  4   byte enables to memory
//   o_mem_we      out  1   write strobe to memory
//   i_mem_dout    in  32   memory read data, valid the cycle after address
// ============================================================================
module dm_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned STARVE_MAX = c_STARVE_MAX_DEF,
  parameter int unsigned MAX_BURST  = c_MAX_BURST_DEF,
  parameter logic [31:0] DM_TOP     = c_DM_TOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [3:0]  i_cpu_be,
  output logic        o_cpu_stall,
  output logic        o_cpu_rvalid,
  output logic        o_cpu_err,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  input  logic [3:0]  i_dma_be,
  input  logic        i_dma_lock,
  output logic        o_dma_gnt,
  output logic        o_dma_rvalid,
  output logic        o_dma_err,
  output logic [31:0] o_rdata,
  output logic [11:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  output logic [3:0]  o_mem_be,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_dout
);

  localparam int unsigned c_SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned c_BW = $clog2(MAX_BURST + 1);
  localparam logic [c_SW-1:0] c_STARVE_LIM = c_SW'(STARVE_MAX);
  localparam logic [c_BW-1:0] c_BURST_LIM  = c_BW'(MAX_BURST);
  localparam logic [c_BW-1:0] c_BURST_ONE  = c_BW'(1);

  // --------------------------------------------------------------------------
  // Arbitration state
  // --------------------------------------------------------------------------
  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [c_SW-1:0] r_starve_cnt;
  logic [c_SW-1:0] w_starve_nxt;
  logic [c_BW-1:0] r_burst_cnt;
  logic [c_BW-1:0] w_burst_nxt;

  logic            w_burst_hold;
  logic            w_starved;
  logic            w_cpu_gnt;
  logic            w_dma_gnt;
  logic            w_any_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_NORM;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant decision. A burst only holds while DMA keeps both req and lock;
  // dropping either falls back to normal priority in that same cycle.
  // No grant is given while reset is asserted so nothing is written.
  // --------------------------------------------------------------------------
  always_comb begin
    w_burst_hold = (r_state == S_BURST) && i_dma_req && i_dma_lock;
    w_starved    = (r_starve_cnt == c_STARVE_LIM);
    w_dma_gnt    = 1'b0;
    w_cpu_gnt    = 1'b0;
    if (!rst) begin
      if (w_burst_hold) begin
        w_dma_gnt = 1'b1;
      end else if (i_dma_req && (w_starved || !i_cpu_req)) begin
        w_dma_gnt = 1'b1;
      end else begin
        w_cpu_gnt = i_cpu_req;
      end
    end
  end

  assign w_any_gnt = w_cpu_gnt | w_dma_gnt;

  // --------------------------------------------------------------------------
  // Next state and counters
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = S_NORM;
    w_burst_nxt  = '0;
    w_starve_nxt = r_starve_cnt;

    case (r_state)
      S_NORM: begin
        // Entering a burst counts the entry grant as beat one; a cap of one
        // beat therefore never leaves normal mode.
        if (w_dma_gnt && i_dma_lock && (c_BURST_LIM != c_BURST_ONE)) begin
          w_state_nxt = S_BURST;
          w_burst_nxt = c_BURST_ONE;
        end
      end
      S_BURST: begin
        if (w_burst_hold) begin
          // Leaving at the cap guarantees the following cycle is decided
          // with CPU priority even though lock is still asserted.
          if ((r_burst_cnt + c_BURST_ONE) != c_BURST_LIM) begin
            w_state_nxt = S_BURST;
            w_burst_nxt = r_burst_cnt + c_BURST_ONE;
          end
        end else if (w_dma_gnt && i_dma_lock &&
                     (c_BURST_LIM != c_BURST_ONE)) begin
          w_state_nxt = S_BURST;
          w_burst_nxt = c_BURST_ONE;
        end
      end
      default: begin
        w_state_nxt = S_NORM;
      end
    endcase

    if (w_dma_gnt || !i_dma_req) begin
      w_starve_nxt = '0;
    end else if (!w_starved) begin
      w_starve_nxt = r_starve_cnt + c_SW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Memory drive. With no grant the CPU fields are presented and the write
  // strobe stays low.
  // --------------------------------------------------------------------------
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_be;
  logic        w_sel_we;
  logic        w_in_range;

  assign w_sel_addr  = w_dma_gnt ? i_dma_addr  : i_cpu_addr;
  assign w_sel_wdata = w_dma_gnt ? i_dma_wdata : i_cpu_wdata;
  assign w_sel_be    = w_dma_gnt ? i_dma_be    : i_cpu_be;
  assign w_sel_we    = w_dma_gnt ? i_dma_we    : i_cpu_we;
  assign w_in_range  = addr_in_range(w_sel_addr, DM_TOP);

  assign o_mem_addr = w_sel_addr[13:2];
  assign o_mem_din  = w_sel_wdata;
  assign o_mem_be   = w_sel_be;
  assign o_mem_we   = w_any_gnt & w_sel_we & w_in_range;

  assign o_dma_gnt   = w_dma_gnt;
  assign o_cpu_stall = i_cpu_req & ~w_cpu_gnt & ~rst;

  // --------------------------------------------------------------------------
  // Response stage
  // --------------------------------------------------------------------------
  arb_resp u_resp (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (w_any_gnt),
    .i_owner_dma  (w_dma_gnt),
    .i_read       (~w_sel_we),
    .i_err        (~w_in_range),
    .i_mem_dout   (i_mem_dout),
    .o_cpu_rvalid (o_cpu_rvalid),
    .o_cpu_err    (o_cpu_err),
    .o_dma_rvalid (o_dma_rvalid),
    .o_dma_err    (o_dma_err),
    .o_rdata      (o_rdata)
  );

endmodule : dm_arbiter
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Self-checking bench for dm_arbiter. A behavioural memory
//               sits on the memory port; a reference model tracks arbitration
//               mode, starvation and burst beats as plain integers and keeps
//               its own image of memory contents to predict read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  localparam int          STARVE = 8;
  localparam int          BURST  = 16;
  localparam logic [31:0] TOP    = 32'h0000_2FFF;
  localparam int          WORDS  = 3072;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_be = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [3:0]  dma_be = '0;
  logic        o_cpu_stall, o_cpu_rvalid, o_cpu_err;
  logic        o_dma_gnt, o_dma_rvalid, o_dma_err;
  logic [31:0] o_rdata, o_mem_din, mem_dout;
  logic [11:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic        o_mem_we;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_MAX(STARVE), .MAX_BURST(BURST), .DM_TOP(TOP)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_be(cpu_be),
    .o_cpu_stall(o_cpu_stall), .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_err(o_cpu_err),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_be(dma_be), .i_dma_lock(dma_lock),
    .o_dma_gnt(o_dma_gnt), .o_dma_rvalid(o_dma_rvalid), .o_dma_err(o_dma_err),
    .o_rdata(o_rdata), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
    .o_mem_be(o_mem_be), .o_mem_we(o_mem_we), .i_mem_dout(mem_dout)
  );

  // Behavioural data memory with a one-cycle read latency and a preload port.
  logic [31:0] mem [0:WORDS-1];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (o_mem_we && (o_mem_addr < 12'd3072)) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_din[8*b +: 8];
      wr_count <= wr_count + 1;
    end
    mem_dout <= (o_mem_addr < 12'd3072) ? mem[o_mem_addr] : 32'h0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [0:WORDS-1];
  bit          m_burst = 0;
  int          m_beats = 0;
  int          m_starve = 0;
  bit          e_cpu_rv = 0, e_cpu_err = 0, e_dma_rv = 0, e_dma_err = 0;
  logic [31:0] e_rdata = '0;

  // Requester generators
  int          cpu_mode = 0, dma_mode = 0, dma_left = 0;
  bit          cpu_pend = 0, dma_pend = 0;
  bit          g_cpu_we = 0, g_dma_we = 0;
  logic [31:0] g_cpu_addr = '0, g_cpu_wdata = '0, g_dma_addr = '0, g_dma_wdata = '0;
  logic [3:0]  g_cpu_be = '0, g_dma_be = '0;

  bit          gnt_log[$];
  bit          stall_log[$];
  logic        last_cpu_rv, last_cpu_err;
  logic [31:0] last_rdata;

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      0: return 32'h0000_3000 + (32'($urandom_range(0, 255)) << 2);
      1: return 32'h0000_2FFC;
      2: return 32'h0000_2FFF;
      3: return 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, WORDS - 1)) << 2;
    endcase
  endfunction

  task automatic gen_cpu();
    if (cpu_mode == 0) begin
      cpu_req = 0; cpu_pend = 0;
    end else if (!cpu_pend) begin
      if (cpu_mode == 1) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = $urandom;
        cpu_be    = 4'($urandom_range(0, 15));
      end else begin
        cpu_req = 1; cpu_we = g_cpu_we; cpu_addr = g_cpu_addr;
        cpu_wdata = g_cpu_wdata; cpu_be = g_cpu_be;
      end
      cpu_pend = cpu_req;
    end
  endtask

  task automatic gen_dma();
    if (dma_mode == 0 || (dma_mode == 2 && dma_left == 0)) begin
      dma_req = 0; dma_lock = 0; dma_pend = 0;
    end else if (!dma_pend) begin
      if (dma_mode == 1) begin
        dma_req   = ($urandom_range(0, 3) != 0);
        dma_lock  = ($urandom_range(0, 2) == 0);
        dma_we    = 1'($urandom_range(0, 1));
        dma_addr  = rand_addr();
        dma_wdata = $urandom;
        dma_be    = 4'($urandom_range(0, 15));
      end else if (dma_mode == 2) begin
        dma_req = 1; dma_lock = 1; dma_we = g_dma_we; dma_addr = g_dma_addr;
        dma_wdata = $urandom; dma_be = 4'hF;
      end else begin
        dma_req = 1; dma_lock = 0; dma_we = g_dma_we; dma_addr = g_dma_addr;
        dma_wdata = g_dma_wdata; dma_be = g_dma_be;
      end
      dma_pend = dma_req;
    end
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic step(input bit do_rst);
    bit          hold, dw, cw, inr, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic [11:0] widx;
    @(posedge clk); #1;
    rst = do_rst;
    gen_cpu();
    gen_dma();
    @(negedge clk);

    if (do_rst) begin
      dw = 0; cw = 0;
    end else begin
      hold = m_burst && dma_req && dma_lock;
      dw   = hold || (dma_req && (!cpu_req || m_starve >= STARVE));
      cw   = cpu_req && !dw;
    end

    // Response of the previous cycle (dropped while in reset)
    check_eq("cpu_rvalid", o_cpu_rvalid, do_rst ? 1'b0 : e_cpu_rv);
    check_eq("cpu_err",    o_cpu_err,    do_rst ? 1'b0 : e_cpu_err);
    check_eq("dma_rvalid", o_dma_rvalid, do_rst ? 1'b0 : e_dma_rv);
    check_eq("dma_err",    o_dma_err,    do_rst ? 1'b0 : e_dma_err);
    if (!do_rst && (e_cpu_rv || e_dma_rv)) check_eq("rdata", o_rdata, e_rdata);
    last_cpu_rv  = o_cpu_rvalid;
    last_cpu_err = o_cpu_err;
    last_rdata   = o_rdata;

    // Grant and memory drive of this cycle
    check_eq("dma_gnt",   o_dma_gnt,   dw);
    check_eq("cpu_stall", o_cpu_stall, cpu_req && !cw && !do_rst);
    gnt_log.push_back(o_dma_gnt);
    stall_log.push_back(o_cpu_stall);

    s_addr  = dw ? dma_addr  : cpu_addr;
    s_wdata = dw ? dma_wdata : cpu_wdata;
    s_be    = dw ? dma_be    : cpu_be;
    s_we    = dw ? dma_we    : cpu_we;
    inr     = (s_addr <= TOP);
    widx    = s_addr[13:2];
    check_eq("mem_we", o_mem_we, (dw || cw) && s_we && inr);
    if (dw || cw) begin
      check_eq("mem_addr", o_mem_addr, widx);
      if (s_we && inr) begin
        check_eq("mem_din", o_mem_din, s_wdata);
        check_eq("mem_be",  o_mem_be,  s_be);
      end
    end

    // Advance the model
    e_cpu_rv  = cw && !s_we && inr;
    e_cpu_err = cw && !inr;
    e_dma_rv  = dw && !s_we && inr;
    e_dma_err = dw && !inr;
    if ((dw || cw) && !s_we && inr) e_rdata = ref_mem[widx];
    if ((dw || cw) && s_we && inr)
      for (int b = 0; b < 4; b++)
        if (s_be[b]) ref_mem[widx][8*b +: 8] = s_wdata[8*b +: 8];

    if (do_rst) begin
      m_burst = 0; m_beats = 0; m_starve = 0;
    end else if (dw) begin
      m_starve = 0;
      if (hold) begin
        m_beats++;
        if (m_beats >= BURST) begin m_burst = 0; m_beats = 0; end
      end else if (dma_lock) begin
        m_burst = 1; m_beats = 1;
      end else begin
        m_burst = 0; m_beats = 0;
      end
    end else begin
      m_burst = 0; m_beats = 0;
      m_starve = dma_req ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
    end

    if (cw) cpu_pend = 0;
    if (dw) begin
      dma_pend = 0;
      if (dma_mode == 2) begin dma_left--; g_dma_addr += 32'd4; end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  task automatic idle_all();
    cpu_mode = 0; dma_mode = 0;
    steps(2);
  endtask

  initial begin
    int wr_before;

    // Preload memory while reset is held
    for (int i = 0; i < WORDS; i++) begin
      @(posedge clk); #1;
      pl_en   = 1'b1;
      pl_addr = 12'(i);
      pl_data = {16'(i), ~16'(i)};
      if (i == 4) pl_data = 32'hDEAD_BEEF;
      if (i == 8) pl_data = 32'hAABB_CCDD;
      ref_mem[i] = pl_data;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
    check_eq("rst_dma_gnt",   o_dma_gnt,    1'b0);
    check_eq("rst_cpu_stall", o_cpu_stall,  1'b0);
    check_eq("rst_mem_we",    o_mem_we,     1'b0);
    check_eq("rst_cpu_rv",    o_cpu_rvalid, 1'b0);
    check_eq("rst_dma_rv",    o_dma_rvalid, 1'b0);
    check_eq("rst_errs",      {o_cpu_err, o_dma_err}, 2'b00);

    // CPU-only read of the preloaded word at 0x0010
    cpu_mode = 2; g_cpu_we = 0; g_cpu_addr = 32'h10;
    gnt_log.delete(); stall_log.delete();
    step(1'b0);
    cpu_mode = 0;
    step(1'b0);
    check_eq("a_no_stall", stall_log[0], 1'b0);
    check_eq("a_rvalid",   last_cpu_rv,  1'b1);
    check_eq("a_rdata",    last_rdata,   32'hDEAD_BEEF);

    // Both requesting continuously: DMA gets every ninth slot
    cpu_mode = 2; g_cpu_we = 0; g_cpu_addr = 32'h40;
    dma_mode = 3; g_dma_we = 0; g_dma_addr = 32'h80;
    gnt_log.delete(); stall_log.delete();
    steps(18);
    for (int i = 0; i < 8; i++) check_eq("b_cpu_first", gnt_log[i], 1'b0);
    check_eq("b_dma_slot9",  gnt_log[8],   1'b1);
    check_eq("b_stall9",     stall_log[8], 1'b1);
    check_eq("b_cpu_again",  gnt_log[9],   1'b0);
    check_eq("b_dma_slot18", gnt_log[17],  1'b1);
    idle_all();

    // Locked burst of 20 writes, CPU joins from beat 5
    dma_mode = 2; g_dma_we = 1; g_dma_addr = 32'h100; dma_left = 20;
    gnt_log.delete(); stall_log.delete();
    steps(4);
    cpu_mode = 2; g_cpu_we = 0; g_cpu_addr = 32'h44;
    steps(28);
    for (int i = 0; i < 16; i++) check_eq("c_burst_hold", gnt_log[i], 1'b1);
    check_eq("c_cap_cpu",    gnt_log[16],   1'b0);
    check_eq("c_cap_nostal", stall_log[16], 1'b0);
    check_eq("c_dma_resume", gnt_log[24],   1'b1);
    idle_all();

    // CPU write outside the mapped range
    wr_before = wr_count;
    cpu_mode = 2; g_cpu_we = 1; g_cpu_addr = 32'h3000;
    g_cpu_wdata = 32'h0BAD_0BAD; g_cpu_be = 4'hF;
    step(1'b0);
    cpu_mode = 0;
    step(1'b0);
    check_eq("d_err",     last_cpu_err, 1'b1);
    check_eq("d_norv",    last_cpu_rv,  1'b0);
    check_eq("d_nowrite", wr_count, wr_before);

    // DMA half-word write then CPU read of the same word
    dma_mode = 3; g_dma_we = 1; g_dma_addr = 32'h20;
    g_dma_wdata = 32'h1234_5678; g_dma_be = 4'b0011;
    step(1'b0);
    dma_mode = 0;
    cpu_mode = 2; g_cpu_we = 0; g_cpu_addr = 32'h20;
    step(1'b0);
    cpu_mode = 0;
    step(1'b0);
    check_eq("e_rvalid", last_cpu_rv, 1'b1);
    check_eq("e_rdata",  last_rdata,  32'hAABB_5678);

    // Reset during beat 3 of a locked read burst
    dma_mode = 2; g_dma_we = 0; g_dma_addr = 32'h200; dma_left = 10;
    gnt_log.delete(); stall_log.delete();
    steps(2);
    step(1'b1);
    cpu_mode = 2; g_cpu_we = 0; g_cpu_addr = 32'h48;
    step(1'b0);
    check_eq("f_rst_nognt",  gnt_log[2],   1'b0);
    check_eq("f_cpu_wins",   gnt_log[3],   1'b0);
    check_eq("f_cpu_nostal", stall_log[3], 1'b0);
    steps(3);
    idle_all();

    // Randomised traffic on both ports
    cpu_mode = 1; dma_mode = 1;
    steps(3000);
    idle_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dm_arbiter
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single 12 KB data memory (`dm_12k`) between the multi-cycle CPU datapath and a DMA/loader requester. It decides each cycle which requester drives the memory address/data/byte-enable/write-enable, returns read data with a fixed one-cycle latency, and raises a stall toward the CPU control unit when the CPU loses arbitration. It sits between the CPU's `alu_out`/`busb`/`be`/`dm_we` path and the memory macro, inside `mips`.

## Interface
- `STARVE_MAX`, 8: consecutive denied DMA-request cycles before DMA is forced a slot.
- `MAX_BURST`, 16: maximum consecutive locked DMA grants.
- `DM_TOP`, 32'h2FFF: highest byte address mapped to data memory.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  CPU write (1) / read (0)
- `cpu_addr`  in  32  CPU byte address
- `cpu_wdata`  in  32  CPU write data
- `cpu_be`  in  4  CPU byte enables
- `cpu_stall`  out  1  CPU request pending but not granted this cycle
- `cpu_rvalid`  out  1  CPU read data valid (one-cycle pulse)
- `cpu_err`  out  1  CPU access outside `[0, DM_TOP]` (one-cycle pulse)
- `dma_req`, `dma_we`, `dma_addr[31:0]`, `dma_wdata[31:0]`, `dma_be[3:0]`  in  requester-1 equivalents
- `dma_lock`  in  1  request to keep grant for a burst
- `dma_gnt`  out  1  DMA granted this cycle
- `dma_rvalid`, `dma_err`  out  1  as for CPU
- `rdata`  out  32  read data, shared; qualified by `*_rvalid`
- `mem_addr`  out  12  word address `[13:2]` to memory
- `mem_din`  out  32  write data to memory
- `mem_be`  out  4  byte enables
- `mem_we`  out  1  write strobe
- `mem_dout`  in  32  memory read data, valid the cycle after address

## Operation
- Grant is combinational from registered state and current requests; requester holds all fields stable while `req`=1 and not granted.
- State machine `S_NORM`, `S_BURST`:
  - `S_NORM`: priority CPU > DMA, except when `starve_cnt == STARVE_MAX`; then DMA wins even if CPU requests.
  - DMA granted with `dma_lock`=1 in `S_NORM` → `S_BURST`, `burst_cnt` := 1.
  - `S_BURST`: DMA wins unconditionally while `dma_req && dma_lock`; `burst_cnt` increments per grant. Exit to `S_NORM` on `dma_lock`=0, `dma_req`=0, or `burst_cnt == MAX_BURST`. The cap exit forces one CPU-priority cycle and takes effect even if lock stays high.
- `starve_cnt`: +1 each cycle `dma_req` && !`dma_gnt`, saturating at `STARVE_MAX`; cleared on any DMA grant or when `dma_req`=0.
- Address check on the granted requester: `addr > DM_TOP` → `mem_we` forced 0. Next cycle the requester's `*_err` pulses; no `rvalid` is issued.
- In-range read: `*_rvalid` pulses the next cycle with `rdata = mem_dout`. In-range write: `mem_we`=1 during the grant cycle; no rvalid.
- No grant: `mem_we`=0, `mem_addr`/`mem_din`/`mem_be` hold the CPU fields (don't-care).

## Timing
- Reset values: state `S_NORM`, counters 0, `cpu_stall` 0, `dma_gnt` 0, all `rvalid`/`err` 0, `mem_we` 0.
- Grant and memory drive in cycle N. `rvalid`/`err`/`rdata` follow in cycle N+1. Back-to-back grants are allowed, giving one access per cycle.
- `cpu_stall = cpu_req & ~cpu_granted`, combinational, same cycle.
- Simultaneous `cpu_req` and `dma_req` with `starve_cnt < STARVE_MAX` in `S_NORM`: CPU wins.
- `rst` asserted mid-burst: next cycle is `S_NORM` and any pending response pulse is dropped.

## Structure
- Shared package `mips_pkg`: state encoding (`S_NORM`/`S_BURST`), `DM_TOP`, default `STARVE_MAX`/`MAX_BURST`.
- One natural sub-module, `arb_resp`: the registered response stage holding owner id, `rvalid`/`err` flags and `rdata` capture.

## Test plan
- CPU-only read of 0x0010 after memory preload 0xDEADBEEF → no stall; next cycle `cpu_rvalid`=1, `rdata`=0xDEADBEEF.
- CPU and DMA both requesting continuously → CPU granted 8 cycles; DMA granted on cycle 9 with `cpu_stall`=1 that cycle; pattern repeats.
- DMA locked burst of 20 writes with CPU idle, then CPU request from burst beat 5 → DMA holds 16 grants; CPU granted on cycle 17; DMA resumes after.
- CPU write to 0x3000 → `mem_we`=0; next cycle `cpu_err`=1, `cpu_rvalid`=0; memory unchanged.
- DMA write with `dma_be`=4'b0011 to 0x0020, then CPU read of the same address → `rdata` low half updated, upper half unchanged.
- `rst` pulsed during `S_BURST` beat 3 → next cycle no grant latched, counters 0, `rvalid` 0; CPU wins the next simultaneous request.
